// File: rtl/pwm_pkg.sv
// Shared types and helpers for the PWM capture block.
// State encoding, counter width derivation, saturation constant.
package pwm_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      MEAS_HIGH = 2'd1,
      MEAS_LOW  = 2'd2
   } state_e;

   // Counter must hold a full 2^bits period without saturating.
   function automatic int cnt_bits_f(input int bits);
      return bits + 1;
   endfunction

   // Low `width` bits set; used as the counter saturation value.
   function automatic logic [31:0] all_ones_f(input int width);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < 32; i++)
         if (i < width) r[i] = 1'b1;
      return r;
   endfunction

endpackage

// File: rtl/pwm_sync_edge.sv
// Input synchroniser with registered rise/fall flags.
// s is the synchronised line; rise/fall lag s by one cycle.
module pwm_sync_edge #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic pwm_in,
   output logic s,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] sync_q;
   logic              prev_q;
   logic              rise_q;
   logic              fall_q;

   assign s    = sync_q[STAGES-1];
   assign rise = rise_q;
   assign fall = fall_q;

   // Shift the line through the synchroniser and register edge flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         prev_q <= 1'b0;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], pwm_in};
         prev_q <= s;
         rise_q <= s & ~prev_q;
         fall_q <= ~s & prev_q;
      end
   end

endmodule

// File: rtl/pwm_capture.sv
// Measures period and high time of an external PWM line.
// Publishes each measurement with a one-cycle valid strobe.
module pwm_capture
   import pwm_pkg::*;
#(
   parameter int BITS        = 16,
   parameter int CNT_BITS    = cnt_bits_f(BITS),
   parameter int SYNC_STAGES = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                pwm_in,
   output logic [CNT_BITS-1:0] period,
   output logic [CNT_BITS-1:0] high_time,
   output logic                valid,
   output logic                stuck
);

   localparam logic [CNT_BITS-1:0] ONES = CNT_BITS'(all_ones_f(CNT_BITS));
   localparam logic [CNT_BITS-1:0] ONE  = CNT_BITS'(1);

   state_e              state_q, state_d;
   logic [CNT_BITS-1:0] cnt_q, cnt_d;
   logic [CNT_BITS-1:0] hi_q, hi_d;
   logic [CNT_BITS-1:0] per_q, per_d;
   logic [CNT_BITS-1:0] ht_q, ht_d;
   logic                valid_q, valid_d;
   logic                stuck_q, stuck_d;
   logic                s, rise, fall;
   logic                sat, timeout;

   pwm_sync_edge #(
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk    (clk),
      .rst_n  (rst_n),
      .pwm_in (pwm_in),
      .s      (s),
      .rise   (rise),
      .fall   (fall)
   );

   assign sat       = (cnt_q == ONES);
   assign timeout   = sat & ~rise & ~fall;
   assign period    = per_q;
   assign high_time = ht_q;
   assign valid     = valid_q;
   assign stuck     = stuck_q;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next state: an edge always beats the timeout.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:      if (rise) state_d = MEAS_HIGH;
         MEAS_HIGH: begin
            if (fall)         state_d = MEAS_LOW;
            else if (timeout) state_d = IDLE;
         end
         MEAS_LOW: begin
            if (rise)         state_d = MEAS_HIGH;
            else if (timeout) state_d = IDLE;
         end
         default:   state_d = IDLE;
      endcase
   end

   // Counter and result updates, sampled from pre-update counter.
   always_comb begin
      cnt_d   = cnt_q;
      hi_d    = hi_q;
      per_d   = per_q;
      ht_d    = ht_q;
      valid_d = 1'b0;
      stuck_d = stuck_q;
      unique case (state_q)
         IDLE: if (rise) cnt_d = ONE;
         MEAS_HIGH: begin
            if (rise)      cnt_d = ONE;
            else if (!sat) cnt_d = cnt_q + ONE;
            if (fall) hi_d = cnt_q;
            if (timeout) begin
               stuck_d = 1'b1;
               per_d   = '0;
               ht_d    = s ? ONES : '0;
            end
         end
         MEAS_LOW: begin
            if (rise)      cnt_d = ONE;
            else if (!sat) cnt_d = cnt_q + ONE;
            if (rise) begin
               per_d   = cnt_q;
               ht_d    = hi_q;
               valid_d = 1'b1;
               stuck_d = 1'b0;
            end else if (timeout) begin
               stuck_d = 1'b1;
               per_d   = '0;
               ht_d    = s ? ONES : '0;
            end
         end
         default: ;
      endcase
   end

   // Datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         hi_q    <= '0;
         per_q   <= '0;
         ht_q    <= '0;
         valid_q <= 1'b0;
         stuck_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         per_q   <= per_d;
         ht_q    <= ht_d;
         valid_q <= valid_d;
         stuck_q <= stuck_d;
      end
   end

endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture (BITS=4, CNT_BITS=5).
// Scoreboard of expected measurements checked on each valid.
module tb_pwm_capture;

   localparam int CW  = 5;
   localparam int LAT = 4;
   localparam int TMO = 35;

   logic          clk;
   logic          rst_n;
   logic          pwm_in;
   logic [CW-1:0] period;
   logic [CW-1:0] high_time;
   logic          valid;
   logic          stuck;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   typedef struct {
      int per;
      int ht;
      int t;
   } exp_t;

   typedef struct {
      int hi;
      int lo;
      int n;
      int per;
      int ht;
   } rec_t;

   exp_t q[$];
   rec_t recs[5];

   pwm_capture #(
      .BITS        (4),
      .CNT_BITS    (CW),
      .SYNC_STAGES (2)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .pwm_in    (pwm_in),
      .period    (period),
      .high_time (high_time),
      .valid     (valid),
      .stuck     (stuck)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   // Scoreboard monitor: every valid must match the oldest expectation.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         cyc++;
         #1;
         if (valid === 1'b1) begin
            if (q.size() == 0) begin
               check("unexpected_valid", 1, 0);
            end else begin
               e = q.pop_front();
               check("period", int'(period), e.per);
               check("high_time", int'(high_time), e.ht);
               check("latency", cyc - e.t, LAT);
               check("stuck_on_valid", int'(stuck), 0);
            end
         end
      end
   end

   task automatic drive(input logic v);
      @(negedge clk);
      pwm_in = v;
   endtask

   task automatic waves(input int hi, input int lo, input int n,
                        input int per, input int ht,
                        output int last_t);
      exp_t e;
      last_t = 0;
      for (int k = 0; k < n; k++) begin
         drive(1'b1);
         last_t = cyc;
         if (k > 0) begin
            e.per = per;
            e.ht  = ht;
            e.t   = cyc;
            q.push_back(e);
         end
         repeat (hi - 1) drive(1'b1);
         repeat (lo) drive(1'b0);
      end
   endtask

   task automatic flush(input string name);
      repeat (8) @(negedge clk);
      check(name, q.size(), 0);
      q.delete();
   endtask

   task automatic reset_pulse(input string name);
      @(negedge clk);
      rst_n  = 1'b0;
      pwm_in = 1'b0;
      @(negedge clk);
      check({name, "_period"}, int'(period), 0);
      check({name, "_high"}, int'(high_time), 0);
      check({name, "_valid"}, int'(valid), 0);
      check({name, "_stuck"}, int'(stuck), 0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic wait_stuck(input string name, input int t0,
                             input int exp_ht);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 60 && !seen; i++) begin
         @(posedge clk);
         #1;
         if (stuck === 1'b1) seen = 1'b1;
      end
      check({name, "_seen"}, int'(seen), 1);
      check({name, "_time"}, cyc - t0, TMO);
      check({name, "_period"}, int'(period), 0);
      check({name, "_high"}, int'(high_time), exp_ht);
   endtask

   initial begin
      #300000;
      $display("FAIL global_timeout: got running want finished");
      $fatal(1, "timeout");
   end

   initial begin
      int t;
      recs[0] = '{hi: 1,  lo: 9,  n: 4, per: 10, ht: 1};
      recs[1] = '{hi: 5,  lo: 11, n: 4, per: 16, ht: 5};
      recs[2] = '{hi: 3,  lo: 5,  n: 3, per: 8,  ht: 3};
      recs[3] = '{hi: 10, lo: 21, n: 3, per: 31, ht: 10};
      recs[4] = '{hi: 7,  lo: 1,  n: 3, per: 8,  ht: 7};

      rst_n  = 1'b0;
      pwm_in = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_period", int'(period), 0);
      check("rst_high", int'(high_time), 0);
      check("rst_valid", int'(valid), 0);
      check("rst_stuck", int'(stuck), 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      foreach (recs[i]) begin
         waves(recs[i].hi, recs[i].lo, recs[i].n,
               recs[i].per, recs[i].ht, t);
         flush("rec_drain");
         reset_pulse("rec_rst");
      end

      // Line forced high after one rise, then a normal waveform.
      drive(1'b1);
      t = cyc;
      wait_stuck("stuck_hi", t, 31);
      repeat (5) drive(1'b0);
      check("stuck_hold", int'(stuck), 1);
      waves(3, 5, 2, 8, 3, t);
      flush("recover_drain");
      check("stuck_cleared", int'(stuck), 0);
      reset_pulse("s1_rst");

      // Duty 5 then duty 0: line stays low after the last period.
      waves(5, 11, 3, 16, 5, t);
      wait_stuck("stuck_lo", t, 0);
      flush("duty0_drain");
      reset_pulse("s2_rst");

      // Reset asserted while measuring the low phase.
      waves(3, 5, 2, 8, 3, t);
      repeat (2) drive(1'b0);
      check("pre_rst_period", int'(period), 8);
      reset_pulse("mid_rst");
      waves(3, 5, 2, 8, 3, t);
      flush("post_rst_drain");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
